// File: rtl/ps2_receiver_pkg.sv
// ps2_receiver_pkg: shared frame constants and receiver state encoding
package ps2_receiver_pkg;
  localparam int PS2_DATA_BITS = 8;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } ps2_state_t;
endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronise and debounce the raw PS/2 clock, strobe on its falling edge
module ps2_clk_filter import ps2_receiver_pkg::*; #(
  parameter int FILTER_LEN = 8
) (
  input  logic schi_clk,
  input  logic schi_rst,
  input  logic i_raw,
  output logic o_fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0]    r_sync;
  logic          r_filt;
  logic          r_fall;
  logic [CW-1:0] r_cnt;
  // two-flop synchroniser, idle-high preset so reset does not look like an edge
  always_ff @(posedge schi_clk or negedge schi_rst) begin
    if (!schi_rst) r_sync <= 2'b11;
    else           r_sync <= {r_sync[0], i_raw};
  end
  // accept a new level only after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge schi_clk or negedge schi_rst) begin
    if (!schi_rst) begin
      r_filt <= 1'b1;
      r_cnt  <= '0;
      r_fall <= 1'b0;
    end else if (r_sync[1] == r_filt) begin
      r_cnt  <= '0;
      r_fall <= 1'b0;
    end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
      r_filt <= r_sync[1];
      r_cnt  <= '0;
      r_fall <= r_filt;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_fall <= 1'b0;
    end
  end
  assign o_fall = r_fall;
endmodule

// File: rtl/ps2_receiver.sv
// ps2_receiver: PS/2 device-to-host frame receiver with a single-entry acknowledged buffer
module ps2_receiver import ps2_receiver_pkg::*; #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 12500,
  parameter int TO_W           = 14
) (
  input  logic                     schi_clk,
  input  logic                     schi_rst,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     ps2_rdn,
  output logic                     ps2_data_ready,
  output logic [PS2_DATA_BITS-1:0] ps2_scan_code,
  output logic                     ps2_frame_err,
  output logic                     ps2_overrun,
  output logic                     ps2_busy
);
  localparam int BW = $clog2(PS2_DATA_BITS);
  ps2_state_t               r_state;
  logic [1:0]               r_dsync;
  logic [PS2_DATA_BITS-1:0] r_shift;
  logic [PS2_DATA_BITS-1:0] r_code;
  logic [BW-1:0]            r_bits;
  logic [TO_W-1:0]          r_to;
  logic                     r_par;
  logic                     r_ready;
  logic                     r_err;
  logic                     r_ovr;
  logic                     w_fall;
  logic                     w_data;
  logic                     w_ack;
  logic                     w_good;
  logic                     w_timeout;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .schi_clk (schi_clk),
    .schi_rst (schi_rst),
    .i_raw    (ps2_clk),
    .o_fall   (w_fall)
  );

  assign w_data    = r_dsync[1];
  assign w_ack     = ~ps2_rdn & r_ready;
  assign w_good    = w_data & (^r_shift ^ r_par);
  assign w_timeout = (r_state != S_IDLE) && (r_to == TO_W'(TIMEOUT_CYCLES));

  // data pin synchroniser; data is only consumed on a filtered clock fall
  always_ff @(posedge schi_clk or negedge schi_rst) begin
    if (!schi_rst) r_dsync <= 2'b11;
    else           r_dsync <= {r_dsync[0], ps2_data};
  end

  // frame FSM, inter-edge timeout and the acknowledged one-entry buffer
  always_ff @(posedge schi_clk or negedge schi_rst) begin
    if (!schi_rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_code  <= '0;
      r_bits  <= '0;
      r_to    <= '0;
      r_par   <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      r_ovr <= 1'b0;
      r_to  <= (w_fall || r_state == S_IDLE) ? '0 : r_to + 1'b1;
      if (w_ack) r_ready <= 1'b0;
      if (w_timeout) begin
        r_state <= S_IDLE;
        r_err   <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          S_IDLE: begin
            r_state <= w_data ? S_IDLE : S_DATA;
            r_bits  <= '0;
          end
          S_DATA: begin
            r_shift <= {w_data, r_shift[PS2_DATA_BITS-1:1]};
            r_bits  <= r_bits + 1'b1;
            r_state <= (r_bits == BW'(PS2_DATA_BITS - 1)) ? S_PARITY : S_DATA;
          end
          S_PARITY: begin
            r_par   <= w_data;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (!w_good) r_err <= 1'b1;
            else if (r_ready && !w_ack) r_ovr <= 1'b1;
            else begin
              r_code  <= r_shift;
              r_ready <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ps2_data_ready = r_ready;
  assign ps2_scan_code  = r_code;
  assign ps2_frame_err  = r_err;
  assign ps2_overrun    = r_ovr;
  assign ps2_busy       = (r_state != S_IDLE);
endmodule

// File: doc/ps2_receiver.md
Name: ps2_receiver

Overview:
PS/2 keyboard device-to-host receiver. It sits between the board PS/2 pins and the scheduler's keyboard interrupt path, and drives `ps2_data_ready` / `ps2_scan_code` into the scheduler. It deserialises 11-bit frames, checks them, and holds one scan code until the consumer acknowledges it with a one-cycle low pulse on `ps2_rdn`.

Parameters:
- FILTER_LEN, 8: number of consecutive equal samples of synchronised `ps2_clk` required to accept a level change.
- TIMEOUT_CYCLES, 12500: maximum `schi_clk` cycles between accepted falling edges inside a frame before the frame is aborted (250 us at 50 MHz).
- TO_W, 14: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- schi_clk  in  1  system clock
- schi_rst  in  1  asynchronous reset, active-low
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- ps2_data  in  1  raw PS/2 data pin, asynchronous
- ps2_rdn  in  1  consumer acknowledge; active-low, one-cycle pulse
- ps2_data_ready  out  1  a scan code is held and not yet acknowledged
- ps2_scan_code  out  8  held scan code
- ps2_frame_err  out  1  one-cycle pulse on a parity or stop-bit error, or on a timeout
- ps2_overrun  out  1  one-cycle pulse when a good frame is dropped because the buffer is full
- ps2_busy  out  1  high while a frame is in progress (state is not IDLE)

Behaviour:
- Reset (`schi_rst`=0, asynchronous):
  - all outputs 0: `ps2_data_ready`, `ps2_scan_code`=8'h00, `ps2_frame_err`, `ps2_overrun`, `ps2_busy`
  - synchroniser flops and filtered clock preset to 1
  - FSM to IDLE; shift register, bit count and timeout counter cleared
  - reset mid-frame discards the partial frame; there is no recovery of it
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass through 2 synchroniser flops.
  - The filtered clock toggles only after FILTER_LEN consecutive synchronised samples differ from its current value.
  - `fall` = filtered clock 1->0 edge, a one-cycle strobe.
  - Synchronised `ps2_data` is sampled in the same cycle that `fall` is high.
  - Latency from the raw pin edge to `fall` = 2 + FILTER_LEN cycles.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall`, if data=0 (start bit) -> DATA with bit count 0; if data=1 -> stay IDLE and discard.
  - DATA: on `fall`, shift data into bit [7] (LSB first, right shift) and increment the count; after the 8th bit -> PARITY.
  - PARITY: on `fall`, latch the parity bit -> STOP.
  - STOP: on `fall`, frame is good iff stop=1 and XOR(data[7:0], parity)=1 (odd parity). Always -> IDLE.
    - good: go to the buffer logic
    - bad: `ps2_frame_err`=1 for 1 cycle, data discarded
- Timeout:
  - Counter is cleared on every `fall` and in IDLE, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES in any state other than IDLE -> IDLE, `ps2_frame_err` pulse, partial data discarded.
- Buffer / handshake (single entry), evaluated at each `schi_clk` edge:
  - `ps2_rdn`=0 and `ps2_data_ready`=1 -> `ps2_data_ready` 0 next cycle. `ps2_scan_code` keeps its value (not cleared).
  - `ps2_rdn`=0 while `ps2_data_ready`=0 -> ignored.
  - Good frame and `ps2_data_ready`=0 -> load `ps2_scan_code`, `ps2_data_ready`=1 in the cycle after the stop-bit `fall`.
  - Good frame and `ps2_data_ready`=1 with no ack in the same cycle -> new byte dropped, `ps2_scan_code` unchanged, `ps2_overrun` pulse.
  - Good frame and ack in the same cycle -> old code retired, new code loaded, `ps2_data_ready` stays 1, no overrun.
- The consumer samples `ps2_data_ready` at edge N and drives `ps2_rdn` low for cycle N..N+1. The receiver clears at edge N+1, so each code is taken exactly once.
- No host-to-device transmit; `ps2_clk` and `ps2_data` are never driven.

Decomposition:
- Shared defines header: FSM state encodings (2 bits: IDLE=0, DATA=1, PARITY=2, STOP=3) and PS2_DATA_BITS=8.
- Natural sub-module `ps2_clk_filter`: 2-flop synchroniser plus FILTER_LEN debounce plus falling-edge strobe. Instantiated once for `ps2_clk`; `ps2_data` uses only its own 2-flop synchroniser.

Test Plan:
- Clean frame 0x1C: start 0, data LSB first 0,0,1,1,1,0,0,0, parity 0, stop 1, bit period 40 us -> `ps2_data_ready`=1, `ps2_scan_code`=8'h1C; `ps2_rdn` low 1 cycle -> `ps2_data_ready`=0 next edge, `ps2_scan_code` still 8'h1C.
- Parity error: 0x1C frame with parity bit 1 -> one-cycle `ps2_frame_err`, `ps2_data_ready` stays 0, `ps2_busy` falls after the stop bit.
- Overrun and simultaneous ack:
  - 0x1C unacknowledged, then a 0xF0 frame -> `ps2_overrun` pulse, `ps2_scan_code` remains 8'h1C.
  - Repeat with `ps2_rdn` low in the cycle after the 0xF0 stop-bit `fall` -> `ps2_scan_code`=8'hF0, `ps2_data_ready` held 1, no overrun.
- Timeout: start bit + 4 data bits, then idle for TIMEOUT_CYCLES+10 -> `ps2_frame_err` pulse, IDLE; a following full 0x5A frame is received as 8'h5A.
- Glitch rejection: 3-cycle low pulse on `ps2_clk` (< FILTER_LEN) in IDLE and mid-DATA -> no bit sampled; the subsequent frame 0x5A decodes correctly.
- Reset mid-frame: assert `schi_rst` low after 5 data bits -> all outputs 0 immediately; after release, a full 0x1C frame decodes as 8'h1C.
